// File: rtl/fetch_stage_imem_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request at a time: Imem_req/Imem_addr held until Imem_ready,
// response returned later as an Imem_rvalid pulse with Imem_rdata.
interface fetch_stage_imem_if;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ready;
    logic        Imem_rvalid;
    logic [31:0] Imem_rdata;

    modport master (
        output Imem_req,
        output Imem_addr,
        input  Imem_ready,
        input  Imem_rvalid,
        input  Imem_rdata
    );

    modport slave (
        input  Imem_req,
        input  Imem_addr,
        output Imem_ready,
        output Imem_rvalid,
        output Imem_rdata
    );
endinterface

// File: rtl/fetch_stage_imem.sv
// Fetch stage: owns the PC, issues one imem request at a time and presents
// the fetched instruction to the F/D register with a Valid_f qualifier.
// Handles hazard stalls and execute redirects, dropping a response that was
// already in flight when a redirect arrives.
module fetch_stage_imem #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Stall_f,
    input  logic                        Redirect,
    input  logic [31:0]                 Pc_target,
    fetch_stage_imem_if.master          imem,
    output logic [31:0]                 Ins_f,
    output logic [31:0]                 Pc_f,
    output logic [31:0]                 Pc_plus_f,
    output logic                        Valid_f
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_r;
    logic [31:0] ins_r;
    logic        drop_r;
    logic [31:0] tgt_aligned;

    // Redirect targets are forced onto a word boundary.
    assign tgt_aligned = Pc_target & ~32'h0000_0003;

    // Outputs are pure functions of the registered state.
    assign imem.Imem_req  = (state == REQ);
    assign imem.Imem_addr = pc_r;
    assign Pc_f           = pc_r;
    assign Pc_plus_f      = pc_r + 32'd4;
    assign Valid_f        = (state == HOLD);
    assign Ins_f          = (state == HOLD) ? ins_r : NOP;

    // Fetch FSM with PC, instruction and drop-flag updates; Redirect has
    // priority over both Stall_f and Imem_ready in every state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= REQ;
            pc_r   <= RESET_PC;
            ins_r  <= 32'h0000_0000;
            drop_r <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (Redirect) begin
                        pc_r <= tgt_aligned;
                        // Request at the old PC was taken anyway; its
                        // response must be thrown away.
                        if (imem.Imem_ready) begin
                            state  <= WAIT;
                            drop_r <= 1'b1;
                        end
                    end else if (imem.Imem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (Redirect) begin
                        pc_r <= tgt_aligned;
                        if (imem.Imem_rvalid) begin
                            drop_r <= 1'b0;
                            state  <= REQ;
                        end else begin
                            drop_r <= 1'b1;
                        end
                    end else if (imem.Imem_rvalid) begin
                        if (drop_r) begin
                            drop_r <= 1'b0;
                            state  <= REQ;
                        end else begin
                            ins_r <= imem.Imem_rdata;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (Redirect) begin
                        pc_r  <= tgt_aligned;
                        state <= REQ;
                    end else if (!Stall_f) begin
                        pc_r  <= pc_r + 32'd4;
                        state <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage_imem.sv
// Directed bench for fetch_stage_imem: a table of per-cycle vectors driven
// against a 1-cycle memory model, plus hand-written redirect/reset sequences.
module tb_fetch_stage_imem;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall_f;
    logic        Redirect;
    logic [31:0] Pc_target;
    logic [31:0] Ins_f;
    logic [31:0] Pc_f;
    logic [31:0] Pc_plus_f;
    logic        Valid_f;

    fetch_stage_imem_if imem ();

    fetch_stage_imem #(.RESET_PC(32'h0000_0000)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Stall_f   (Stall_f),
        .Redirect  (Redirect),
        .Pc_target (Pc_target),
        .imem      (imem),
        .Ins_f     (Ins_f),
        .Pc_f      (Pc_f),
        .Pc_plus_f (Pc_plus_f),
        .Valid_f   (Valid_f)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic mem_en = 1'b0;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ins;
        logic [31:0] pcp;
    } vec_t;

    vec_t tbl [31];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] ins, input logic [31:0] pcp);
        chk({tag, " req"},   {31'd0, imem.Imem_req}, {31'd0, req});
        chk({tag, " addr"},  imem.Imem_addr, addr);
        chk({tag, " pc"},    Pc_f, addr);
        chk({tag, " valid"}, {31'd0, Valid_f}, {31'd0, valid});
        chk({tag, " ins"},   Ins_f, ins);
        chk({tag, " pcp"},   Pc_plus_f, pcp);
    endtask

    // One clock. When mem_en is set the bench acts as a 1-cycle memory that
    // answers an accepted request with addr | 0xA000_0000 on the next cycle.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = (imem.Imem_req === 1'b1) && imem.Imem_ready;
        a   = imem.Imem_addr;
        @(posedge Clk);
        #1;
        if (mem_en) begin
            imem.Imem_rvalid = acc;
            imem.Imem_rdata  = a | 32'hA000_0000;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        imem.Imem_rvalid = 1'b0;
    endtask

    initial begin
        //            stall redir tgt            rdy   req   addr           vld   ins            pc+4
        tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, NOP,           32'h4};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, NOP,           32'h4};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'hA000_0000, 32'h4};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0, NOP,           32'h8};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4,         1'b0, NOP,           32'h8};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4,         1'b1, 32'hA000_0004, 32'h8};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b0, NOP,           32'hC};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8,         1'b0, NOP,           32'hC};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8,         1'b1, 32'hA000_0008, 32'hC};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8,         1'b1, 32'hA000_0008, 32'hC};
        tbl[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8,         1'b1, 32'hA000_0008, 32'hC};
        tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8,         1'b1, 32'hA000_0008, 32'hC};
        tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b0, NOP,           32'h10};
        tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hC,         1'b0, NOP,           32'h10};
        tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hC,         1'b1, 32'hA000_000C, 32'h10};
        tbl[15] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        1'b0, NOP,           32'h14};
        tbl[16] = '{1'b0, 1'b1, 32'h100,       1'b1, 1'b0, 32'h10,        1'b0, NOP,           32'h14};
        tbl[17] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100,       1'b0, NOP,           32'h104};
        tbl[18] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h100,       1'b0, NOP,           32'h104};
        tbl[19] = '{1'b0, 1'b1, 32'h20,        1'b1, 1'b0, 32'h100,       1'b1, 32'hA000_0100, 32'h104};
        tbl[20] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        1'b0, NOP,           32'h24};
        tbl[21] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        1'b0, NOP,           32'h24};
        tbl[22] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        1'b0, NOP,           32'h24};
        tbl[23] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h20,        1'b0, NOP,           32'h24};
        tbl[24] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h20,        1'b0, NOP,           32'h24};
        tbl[25] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h20,        1'b0, NOP,           32'h24};
        tbl[26] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h20,        1'b1, 32'hA000_0020, 32'h24};
        tbl[27] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, NOP,           32'h0};
        tbl[28] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, NOP,           32'h0};
        tbl[29] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h0};
        tbl[30] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, NOP,           32'h4};

        Stall_f          = 1'b0;
        Redirect         = 1'b0;
        Pc_target        = 32'h0;
        imem.Imem_ready  = 1'b0;
        imem.Imem_rvalid = 1'b0;
        imem.Imem_rdata  = 32'h0;
        do_reset();

        // Streaming fetch, stall, redirects, ready back-pressure, PC wrap.
        mem_en = 1'b1;
        for (int i = 0; i < 31; i++) begin
            Stall_f         = tbl[i].stall;
            Redirect        = tbl[i].redir;
            Pc_target       = tbl[i].tgt;
            imem.Imem_ready = tbl[i].ready;
            #1;
            chk_out($sformatf("row%0d", i), tbl[i].req, tbl[i].addr,
                    tbl[i].valid, tbl[i].ins, tbl[i].pcp);
            tick();
        end
        mem_en    = 1'b0;
        Stall_f   = 1'b0;
        Redirect  = 1'b0;
        imem.Imem_rvalid = 1'b0;

        // Redirect in WAIT with the response arriving a cycle later: dropped.
        do_reset();
        imem.Imem_ready = 1'b1;
        tick();                                   // REQ@0 accepted -> WAIT
        imem.Imem_ready = 1'b0;
        Redirect  = 1'b1;
        Pc_target = 32'h40;
        tick();                                   // WAIT, drop armed, pc=0x40
        Redirect  = 1'b0;
        chk_out("drop_wait", 1'b0, 32'h40, 1'b0, NOP, 32'h44);
        imem.Imem_rvalid = 1'b1;
        imem.Imem_rdata  = 32'hDEAD_BEEF;
        tick();                                   // stale response discarded
        imem.Imem_rvalid = 1'b0;
        chk_out("drop_req", 1'b1, 32'h40, 1'b0, NOP, 32'h44);
        imem.Imem_ready = 1'b1;
        tick();                                   // REQ@0x40 accepted
        imem.Imem_ready = 1'b0;
        imem.Imem_rvalid = 1'b1;
        imem.Imem_rdata  = 32'h1234_5678;
        tick();
        imem.Imem_rvalid = 1'b0;
        chk_out("drop_hold", 1'b0, 32'h40, 1'b1, 32'h1234_5678, 32'h44);

        // Redirect coinciding with acceptance, then a stray rvalid in REQ.
        do_reset();
        imem.Imem_ready = 1'b1;
        Redirect  = 1'b1;
        Pc_target = 32'h80;
        tick();                                   // WAIT with drop, pc=0x80
        Redirect  = 1'b0;
        imem.Imem_ready = 1'b0;
        chk_out("acc_redir_wait", 1'b0, 32'h80, 1'b0, NOP, 32'h84);
        imem.Imem_rvalid = 1'b1;
        imem.Imem_rdata  = 32'hBAD0_BAD0;
        tick();                                   // dropped -> REQ
        chk_out("acc_redir_req", 1'b1, 32'h80, 1'b0, NOP, 32'h84);
        tick();                                   // rvalid still high in REQ: ignored
        imem.Imem_rvalid = 1'b0;
        chk_out("stray_rvalid", 1'b1, 32'h80, 1'b0, NOP, 32'h84);
        Redirect  = 1'b1;
        Pc_target = 32'h203;
        tick();                                   // unaccepted REQ retargeted, aligned
        Redirect  = 1'b0;
        chk_out("req_redir_align", 1'b1, 32'h200, 1'b0, NOP, 32'h204);

        // Reset asserted while a request is outstanding.
        imem.Imem_ready = 1'b1;
        tick();                                   // -> WAIT
        imem.Imem_ready = 1'b0;
        chk_out("pre_reset_wait", 1'b0, 32'h200, 1'b0, NOP, 32'h204);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk_out("reset_in_wait", 1'b1, 32'h0, 1'b0, NOP, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage_imem.md
Name: fetch_stage_imem

Overview:
Fetch stage feeding the F/D pipeline register. Owns the PC and issues one instruction-memory request at a time over a req/ready + rvalid handshake. Presents Ins_f, Pc_f and Pc_plus_f with a Valid_f qualifier. Honours hazard-unit stalls and branch/jump redirects from execute, including discarding responses that are in flight when a redirect occurs.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
Stall_f  in  1  hazard unit: hold the current instruction (F/D not consuming)
Redirect  in  1  taken branch/jump from execute
Pc_target  in  32  redirect target
Imem_req  out  1  request valid
Imem_addr  out  32  request address (word-aligned)
Imem_ready  in  1  memory accepts request this cycle
Imem_rvalid  in  1  response data valid
Imem_rdata  in  32  response instruction
Ins_f  out  32  instruction to F/D
Pc_f  out  32  PC of Ins_f
Pc_plus_f  out  32  Pc_f + 4
Valid_f  out  1  Ins_f/Pc_f hold a real fetched instruction

Behaviour:
- One clock (Clk); Reset is synchronous, active-high. All state updates occur on the rising edge.
- State: pc_r[31:0], ins_r[31:0], drop_r, FSM {REQ, WAIT, HOLD}.
- Reset: FSM=REQ, pc_r=RESET_PC, ins_r=0, drop_r=0. In the first cycle after reset: Imem_req=1, Imem_addr=RESET_PC, Valid_f=0, Ins_f=32'h0000_0013, Pc_f=RESET_PC, Pc_plus_f=RESET_PC+4. Memory shares Reset and abandons in-flight responses, so reset during WAIT needs no drop.
- Outputs: Imem_req=(FSM==REQ); Imem_addr=pc_r; Pc_f=pc_r; Pc_plus_f=pc_r+4 (mod 2^32, 0xFFFF_FFFC wraps to 0); Valid_f=(FSM==HOLD); Ins_f=ins_r when Valid_f, else NOP 32'h0000_0013.
- REQ: when Imem_ready=1, go to WAIT. Otherwise stay; Imem_addr is stable until accepted.
- WAIT: Imem_req=0. Only one request is outstanding. Response latency is at least 1 cycle after acceptance.
  - On Imem_rvalid with drop_r=0: ins_r<=Imem_rdata, go to HOLD. Valid_f=1 starting the next cycle.
  - On Imem_rvalid with drop_r=1: discard the data, drop_r<=0, go to REQ.
- HOLD: if Stall_f=0, the instruction is consumed at this edge: pc_r<=pc_r+4, go to REQ. If Stall_f=1, stay; all outputs are held stable.
- Redirect (any state, priority over Stall_f and Imem_ready): pc_r<={Pc_target[31:2],2'b00}.
  - REQ, not accepted: stay in REQ; the new address appears next cycle.
  - REQ and Imem_ready in the same cycle: go to WAIT with drop_r<=1 (old request discarded).
  - WAIT: drop_r<=1, stay in WAIT. If Imem_rvalid arrives that same cycle, discard it, drop_r<=0, go to REQ.
  - HOLD: go to REQ; Valid_f drops next cycle.
- Imem_rvalid in REQ or HOLD is ignored.
- Throughput: with 1-cycle memory and no stalls, one instruction every 3 cycles (REQ→WAIT→HOLD).
- F/D register is cleared by the hazard unit when Valid_f=0 at consume.

Test Plan:
1. Reset with RESET_PC=0, Imem_ready=1, 1-cycle memory returning addr|0xA000_0000, Stall_f=0 -> Imem_addr issues 0,4,8. Valid_f pulses once every 3 cycles. Ins_f=0xA000_0000 with Pc_f=0 and Pc_plus_f=4, then 0xA000_0004 with Pc_f=4.
2. Stall_f=1 for 3 cycles while in HOLD (Pc_f=8) -> Ins_f, Pc_f=8 and Valid_f=1 stable, Imem_req=0. After release, next Imem_addr=0xC.
3. Redirect to Pc_target=0x100 while in WAIT for addr 0x10 -> response for 0x10 discarded with Valid_f=0. Next Imem_addr=0x100; next Valid_f has Pc_f=0x100.
4. Imem_ready=0 for 4 cycles in REQ at 0x20 -> Imem_req=1, Imem_addr=0x20 stable throughout. Accepted on the 5th cycle.
5. In HOLD, Redirect=1 with Pc_target=0xFFFF_FFFF and Stall_f=1 -> redirect wins, Imem_addr=0xFFFF_FFFC. When fetched, Pc_plus_f=0x0000_0000.
6. Assert Reset for 1 cycle during WAIT -> next cycle Imem_req=1, Imem_addr=RESET_PC, Valid_f=0, Ins_f=0x0000_0013.
